hram_cmd_gen: RTL

HRAM_CMD_GEN -- requirements
Module: hram_cmd_gen

---
 rtl/hram_pkg.sv | 34 +++
 rtl/hram_cmd_gen.sv | 108 ++++++++++
 2 files changed

// File: rtl/hram_pkg.sv
// Shared definitions for the HyperRAM command generator:
// FSM state encoding, command-address bit positions and the CA packing helper.
package hram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA0,
    ST_CA1,
    ST_CA2,
    ST_WDATA
  } state_t;

  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  // Upper word address goes to CA[44:16], the low three bits to CA[2:0].
  function automatic logic [47:0] ca_pack(
    input logic        write,
    input logic        reg_space,
    input logic        burst_linear,
    input logic [31:0] addr
  );
    logic [47:0] ca;
    ca        = '0;
    ca[CA_RW] = ~write;
    ca[CA_AS] = reg_space;
    ca[CA_BT] = burst_linear;
    ca[44:16] = addr[31:3];
    ca[2:0]   = addr[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/hram_cmd_gen.sv
// HyperRAM command generator: accepts a request, emits the 48-bit CA as three
// 16-bit words (CA valid one cycle after accept), then streams write data through.
module hram_cmd_gen
  import hram_pkg::*;
#(
  parameter bit BURST_LINEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_reg,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] ca_word,
  output logic        ca_valid,
  input  logic        ca_ready,
  output logic        ca_last,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [47:0] r_ca;
  logic        r_write;
  logic [7:0]  r_beats;

  logic [47:0] w_ca_new;
  logic        w_req_fire;
  logic        w_ca_fire;
  logic        w_dout_fire;

  assign w_ca_new    = ca_pack(req_write, req_reg, BURST_LINEAR, req_addr);
  assign w_req_fire  = req_valid && req_ready;
  assign w_ca_fire   = ca_valid && ca_ready;
  assign w_dout_fire = dout_valid && dout_ready;

  // The CA register shifts up one word per accepted beat, so ca_word is always its top slice.
  assign ca_word = r_ca[47:32];
  assign busy    = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    ca_valid    = 1'b0;
    ca_last     = 1'b0;
    dout        = '0;
    dout_valid  = 1'b0;
    dout_last   = 1'b0;
    wr_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_CA0;
      end
      ST_CA0: begin
        ca_valid = 1'b1;
        if (ca_ready) w_state_nxt = ST_CA1;
      end
      ST_CA1: begin
        ca_valid = 1'b1;
        if (ca_ready) w_state_nxt = ST_CA2;
      end
      ST_CA2: begin
        ca_valid = 1'b1;
        ca_last  = 1'b1;
        if (ca_ready) w_state_nxt = r_write ? ST_WDATA : ST_IDLE;
      end
      ST_WDATA: begin
        dout       = wr_data;
        dout_valid = wr_valid;
        wr_ready   = dout_ready;
        dout_last  = (r_beats == 8'd0);
        if (wr_valid && dout_ready && (r_beats == 8'd0)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ca    <= '0;
      r_write <= 1'b0;
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_fire) begin
        r_ca    <= w_ca_new;
        r_write <= req_write;
        // Register writes always carry exactly one data word.
        r_beats <= (req_reg && req_write) ? 8'd0 : req_len;
      end else if (w_ca_fire) begin
        r_ca <= {r_ca[31:0], 16'h0000};
      end
      if (w_dout_fire && (r_beats != 8'd0)) r_beats <= r_beats - 8'd1;
    end
  end

endmodule
